// File: rtl/clock_divider_pkg.sv
// -----------------------------------------------------------------------------
// clock_divider_pkg
// Shared constants for the multi-channel clock divider.
//   CDM_DEFAULT_DIV : ratio every channel holds after reset
//   CDM_MIN_DIV     : smallest ratio that produces a waveform; below this a
//                     channel is held stopped with its outputs low
// -----------------------------------------------------------------------------
package clock_divider_pkg;

    localparam int unsigned CDM_DEFAULT_DIV = 2;
    localparam int unsigned CDM_MIN_DIV     = 2;

endpackage

// File: rtl/clock_divider_multi_div_channel.sv
// -----------------------------------------------------------------------------
// div_channel
// One divider channel: period counter, shadowed ratio with boundary commit,
// and registered clk_out / tick / busy.
// Ports:
//   clk_in     : clock, all logic on rising edge
//   rst        : asynchronous active-high reset
//   i_en       : run enable for this channel
//   i_load     : strobe capturing i_div into the shadow ratio
//   i_div      : ratio field for this channel
//   i_sync     : global phase restart (also forces commit of a pending ratio)
//   o_clk_out  : divided waveform, high for ceil(div/2) cycles of each period
//   o_tick     : one-cycle pulse in the last cycle of each period
//   o_busy     : a loaded ratio is waiting to be committed
// -----------------------------------------------------------------------------
module div_channel
    import clock_divider_pkg::*;
#(
    parameter int W           = 16,
    parameter int DEFAULT_DIV = CDM_DEFAULT_DIV
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_div,
    input  logic         i_sync,
    output logic         o_clk_out,
    output logic         o_tick,
    output logic         o_busy
);

    localparam logic [W-1:0] ONE      = W'(1);
    localparam logic [W-1:0] MIN_DIV  = W'(CDM_MIN_DIV);
    localparam logic [W-1:0] RST_DIV  = W'(DEFAULT_DIV);

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_div_act;
    logic [W-1:0] r_shadow;
    logic         r_clk_out;
    logic         r_tick;
    logic         r_busy;

    logic [W-1:0] w_last;
    logic [W-1:0] w_hi;
    logic [W-1:0] w_next_shadow;
    logic         w_running;
    logic         w_wrap;
    logic         w_commit;

    assign w_running     = i_en && (r_div_act >= MIN_DIV);
    assign w_last        = r_div_act - ONE;
    // High phase is ceil(div/2): odd ratios spend the extra cycle high.
    assign w_hi          = r_div_act - (r_div_act >> 1);
    assign w_wrap        = w_running && (r_cnt == w_last);
    // A stopped channel has no period in flight, so a new ratio can take
    // effect immediately without producing a runt pulse.
    assign w_commit      = i_sync || !w_running || w_wrap;
    // A load arriving on the commit edge goes straight to the active ratio.
    assign w_next_shadow = i_load ? i_div : r_shadow;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div_act <= RST_DIV;
            r_shadow  <= RST_DIV;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_shadow <= w_next_shadow;
            if (w_commit) begin
                r_div_act <= w_next_shadow;
                r_busy    <= 1'b0;
            end else if (i_load) begin
                r_busy    <= 1'b1;
            end

            // sync outranks the wrap so every channel restarts at cnt=0.
            if (i_sync || !w_running) begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
            end else begin
                r_clk_out <= (r_cnt < w_hi);
                r_tick    <= w_wrap;
                r_cnt     <= w_wrap ? '0 : (r_cnt + ONE);
            end
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
    assign o_busy    = r_busy;

endmodule

// File: rtl/clock_divider_multi.sv
// -----------------------------------------------------------------------------
// clock_divider_multi
// N independent clock-enable dividers driven from one input clock, each with
// a runtime ratio that changes only at a period boundary.
// Ports:
//   clk_in  : system clock
//   rst     : asynchronous active-high reset
//   en      : [N]   per-channel run enable
//   load    : [N]   per-channel ratio capture strobe
//   div_in  : [N*W] packed ratios, channel k in bits [k*W +: W]
//   sync    : global phase restart pulse
//   clk_out : [N]   divided waveforms (registered)
//   tick    : [N]   end-of-period pulses (registered)
//   busy    : [N]   pending-ratio flags (registered)
// -----------------------------------------------------------------------------
module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int N           = 4,
    parameter int W           = 16,
    parameter int DEFAULT_DIV = CDM_DEFAULT_DIV
) (
    input  logic           clk_in,
    input  logic           rst,
    input  logic [N-1:0]   en,
    input  logic [N-1:0]   load,
    input  logic [N*W-1:0] div_in,
    input  logic           sync,
    output logic [N-1:0]   clk_out,
    output logic [N-1:0]   tick,
    output logic [N-1:0]   busy
);

    for (genvar k = 0; k < N; k++) begin : g_ch
        logic [W-1:0] w_div;
        assign w_div = div_in[k*W +: W];

        div_channel #(
            .W           (W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_in    (clk_in),
            .rst       (rst),
            .i_en      (en[k]),
            .i_load    (load[k]),
            .i_div     (w_div),
            .i_sync    (sync),
            .o_clk_out (clk_out[k]),
            .o_tick    (tick[k]),
            .o_busy    (busy[k])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// -----------------------------------------------------------------------------
// tb_clock_divider_multi
// Directed opening sequence followed by randomized enables, loads, syncs and
// asynchronous resets, compared every cycle against a per-channel period model.
// -----------------------------------------------------------------------------
module tb_clock_divider_multi;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk_in = 1'b0;
    logic           rst;
    logic [N-1:0]   en;
    logic [N-1:0]   load;
    logic [N*W-1:0] div_in;
    logic           sync;
    logic [N-1:0]   clk_out;
    logic [N-1:0]   tick;
    logic [N-1:0]   busy;

    always #5 clk_in = ~clk_in;

    clock_divider_multi #(.N(N), .W(W), .DEFAULT_DIV(2)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .div_in  (div_in),
        .sync    (sync),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: position inside the current period, active and pending ratio.
    int           m_pos [N];
    int           m_div [N];
    int           m_pend[N];
    logic [N-1:0] m_clk;
    logic [N-1:0] m_tick;
    logic [N-1:0] m_busy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_pos[k]  = 0;
            m_div[k]  = 2;
            m_pend[k] = 2;
        end
        m_clk  = '0;
        m_tick = '0;
        m_busy = '0;
    endtask

    task automatic model_step(input logic [N-1:0] e, input logic [N-1:0] l,
                              input logic [N*W-1:0] d, input logic s);
        for (int k = 0; k < N; k++) begin
            int  div, pos, newv;
            bit  active, last;
            div    = m_div[k];
            pos    = m_pos[k];
            active = e[k] && (div >= 2);
            last   = active && (pos == div - 1);
            newv   = l[k] ? int'(d[k*W +: W]) : m_pend[k];

            if (s || !active) begin
                m_clk[k]  = 1'b0;
                m_tick[k] = 1'b0;
                m_pos[k]  = 0;
            end else begin
                m_clk[k]  = (pos < (div + 1) / 2);
                m_tick[k] = last;
                m_pos[k]  = (pos + 1) % div;
            end

            m_pend[k] = newv;
            if (s || !active || last) begin
                m_div[k]  = newv;
                m_busy[k] = 1'b0;
            end else if (l[k]) begin
                m_busy[k] = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string where);
        check({where, ".clk_out"}, 64'(clk_out), 64'(m_clk));
        check({where, ".tick"},    64'(tick),    64'(m_tick));
        check({where, ".busy"},    64'(busy),    64'(m_busy));
    endtask

    // One clock edge: model consumes the inputs that the DUT sampled.
    task automatic step_cycle(input string where);
        logic [N-1:0]   e_s, l_s;
        logic [N*W-1:0] d_s;
        logic           s_s;
        e_s = en; l_s = load; d_s = div_in; s_s = sync;
        @(posedge clk_in);
        if (rst) model_reset();
        else     model_step(e_s, l_s, d_s, s_s);
        #1;
        compare_all(where);
    endtask

    function automatic logic [W-1:0] pick_ratio();
        int r;
        r = $urandom_range(0, 15);
        if (r < 2)  return W'(r);
        if (r < 14) return W'($urandom_range(2, 9));
        return W'($urandom_range(10, 40));
    endfunction

    initial begin
        int hi0, hi1, tk0;
        rst    = 1'b1;
        en     = '0;
        load   = '0;
        div_in = '0;
        sync   = 1'b0;
        model_reset();

        step_cycle("reset");
        step_cycle("reset");
        check("reset.clk_out", 64'(clk_out), 64'(0));
        check("reset.tick",    64'(tick),    64'(0));
        check("reset.busy",    64'(busy),    64'(0));

        rst = 1'b0;
        en  = '1;
        step_cycle("default1");
        check("default.first_high", 64'(clk_out), 64'hF);
        step_cycle("default2");
        check("default.tick",       64'(tick),    64'hF);
        check("default.low",        64'(clk_out), 64'h0);

        load[0]     = 1'b1;
        div_in[W-1:0] = W'(5);
        step_cycle("load5");
        check("load5.busy", 64'(busy), 64'h1);
        load = '0;
        sync = 1'b1;
        step_cycle("sync");
        check("sync.busy", 64'(busy), 64'h0);
        sync = 1'b0;

        hi0 = 0; hi1 = 0; tk0 = 0;
        for (int c = 0; c < 10; c++) begin
            step_cycle("div5");
            hi0 += int'(clk_out[0]);
            hi1 += int'(clk_out[1]);
            tk0 += int'(tick[0]);
        end
        check("div5.high_count", 64'(hi0), 64'(6));
        check("div5.tick_count", 64'(tk0), 64'(2));
        check("div2.high_count", 64'(hi1), 64'(5));

        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 19) == 0) en[k] = ~en[k];
            load = '0;
            for (int k = 0; k < N; k++) begin
                div_in[k*W +: W] = pick_ratio();
                if ($urandom_range(0, 11) == 0) load[k] = 1'b1;
            end
            sync = ($urandom_range(0, 59) == 0);

            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                #1 model_reset();
                check("async_rst.clk_out", 64'(clk_out), 64'(0));
                check("async_rst.tick",    64'(tick),    64'(0));
                check("async_rst.busy",    64'(busy),    64'(0));
                step_cycle("in_rst");
                #3 rst = 1'b0;
            end
            step_cycle("rand");
        end

        // Forced mid-run reset so the asynchronous path is always exercised.
        en = '1; load = '0; sync = 1'b0;
        step_cycle("pre_rst");
        #2 rst = 1'b1;
        #1 model_reset();
        check("final_rst.clk_out", 64'(clk_out), 64'(0));
        check("final_rst.busy",    64'(busy),    64'(0));
        #3 rst = 1'b0;
        step_cycle("post_rst");
        check("post_rst.default_high", 64'(clk_out), 64'hF);
        step_cycle("post_rst2");
        check("post_rst.default_tick", 64'(tick),    64'hF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Parametrised successor to the single fixed-ratio clock conversion circuit.
- Generates N independent divided clock-enable waveforms from one input clock `clk_in`. Each channel has its own runtime-programmable divide ratio, a per-period tick, and a per-channel enable.
- Ratio changes are glitch-free: they are shadowed and applied only at a period boundary. A global `sync` input phase-aligns all channels.
- Sits between the board oscillator input and slow peripherals that need derived rates, e.g. LED blink, scan, and UART-style ticks.

Parameters:
N, 4, number of output channels.
W, 16, width of each divide-ratio field and counter.
DEFAULT_DIV, 2, active ratio loaded into every channel at reset (must be < 2^W).

Ports:
clk_in  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  N  per-channel run enable.
load  input  N  per-channel strobe that captures that channel's ratio field.
div_in  input  N*W  packed ratios; channel k uses bits [k*W +: W].
sync  input  1  global phase restart, one-cycle pulse.
clk_out  output  N  divided waveform per channel, registered.
tick  output  N  one-cycle pulse per channel in the last cycle of each output period, registered.
busy  output  N  per-channel flag: a loaded ratio is pending commit.

Behaviour:
- Reset (async, rst=1):
  - cnt[k]=0, clk_out=0, tick=0, busy=0.
  - div_act[k]=DEFAULT_DIV, shadow[k]=DEFAULT_DIV.
- Definitions per channel:
  - hi = div_act - (div_act>>1), which is ceil(div/2). Examples: div=2 gives 1 high/1 low; div=3 gives 2/1; div=5 gives 3/2.
  - "running" = en[k]=1 AND div_act[k] >= 2.
- Running channel, each edge:
  - clk_out ← (cnt < hi).
  - tick ← (cnt == div_act-1).
  - cnt ← (cnt == div_act-1) ? 0 : cnt+1.
  - clk_out and tick therefore lag cnt by one cycle. The first clk_out high appears one cycle after en rises. Period is exactly div_act cycles. tick coincides with the final low cycle.
- Not running (en=0 or div_act<2): cnt←0, clk_out←0, tick←0 on the next edge. A later re-enable starts a fresh period from cnt=0. No partial high pulse is produced.
- Load:
  - load[k]=1 captures the field into shadow[k] and sets busy[k].
  - Commit (div_act←shadow, busy←0) occurs on a running channel's wrap edge (cnt==div_act-1), or on any edge where the channel is not running.
  - load and commit on the same edge: the incoming div_in value is committed directly, busy stays 0.
  - Repeated loads before commit: the last value wins.
- Loaded ratio 0 or 1: accepted and committed normally; the channel then stops (output 0) until a ratio >= 2 is committed.
- sync=1:
  - On the next edge every channel's cnt←0, tick←0, clk_out←0.
  - All pending shadows commit; busy←0.
  - Counting resumes the following edge, so all channels with equal ratios are in phase.
  - sync takes priority over wrap. sync + load on the same edge commits the incoming load value.
- Wrap-around: cnt never exceeds div_act-1. Maximum ratio is 2^W-1.
- Reset mid-period: immediate return to the reset values; shadowed values are lost.
- No combinational path from any input to any output.

Decomposition:
- Package clock_divider_pkg: default-ratio constant and the minimum legal ratio constant (2).
- One sub-module is natural: div_channel (single counter, shadow/commit logic, clk_out/tick/busy registers). The top is a generate loop of N div_channel instances plus div_in slicing and sync fan-out.

Test Plan:
- Reset/default: release rst, en=all 1, N=4 → every clk_out toggles with period 2 cycles (1 high/1 low). First high occurs 1 cycle after en. tick pulses every 2 cycles.
- Odd ratio: load ch0=5, wait for commit → clk_out 3 cycles high, 2 low. tick high during the 5th cycle of each period. busy high from the load until the wrap edge.
- Mid-period load: ch1 running div=8; load 3 at cnt=2 → the current 8-cycle period completes unchanged. Next period is 3 cycles. No runt pulse.
- Stop/restart: deassert en[2] mid-high-phase → clk_out[2]=0 on the next edge. Re-assert → high after 1 cycle, full period. Loading 1 → output stays 0.
- sync alignment: ch0=4, ch3=4 with different phases; pulse sync → both clk_out rise on the same edge thereafter. A pending load on ch3 commits at sync.
- Async reset mid-operation: assert rst between edges → all outputs 0 immediately. Ratios return to 2.
